// File: rtl/linelen_frontend_if.sv
// linelen_frontend_if
//   Sample-in / difference-out bundle between a sample source and the
//   line-length front end.
//   master : drives din, din_valid, clr; observes dout, dout_en,
//            win_first, win_last, win_cnt
//   slave  : the front end itself (opposite directions)
interface linelen_frontend_if #(
    parameter int input_width = 36,
    parameter int cnt_width   = 8
);
    logic signed [input_width-1:0] din;
    logic                          din_valid;
    logic                          clr;
    logic signed [input_width:0]   dout;
    logic                          dout_en;
    logic                          win_first;
    logic                          win_last;
    logic [cnt_width-1:0]          win_cnt;

    modport master (
        output din, din_valid, clr,
        input  dout, dout_en, win_first, win_last, win_cnt
    );

    modport slave (
        input  din, din_valid, clr,
        output dout, dout_en, win_first, win_last, win_cnt
    );
endinterface

// File: rtl/linelen_frontend.sv
// linelen_frontend
//   Forms |x[n] - x[n-1]| from a stream of signed samples and frames the
//   differences into contiguous windows of win_len entries for the
//   downstream accumulator.
//   clk            : system clock, rising edge
//   rst            : asynchronous reset, active high
//   bus.din        : signed sample (input_width bits)
//   bus.din_valid  : din valid this cycle
//   bus.clr        : synchronous restart (drop previous sample and window position)
//   bus.dout       : absolute difference, input_width+1 bits, always >= 0
//   bus.dout_en    : one-cycle strobe, dout valid
//   bus.win_first  : qualifies dout_en, first difference of a window
//   bus.win_last   : qualifies dout_en, last difference of a window
//   bus.win_cnt    : index of dout within its window
module linelen_frontend #(
    parameter int input_width = 36,
    parameter int win_len     = 256,
    parameter int cnt_width   = 8
) (
    input logic              clk,
    input logic              rst,
    linelen_frontend_if.slave bus
);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [cnt_width-1:0] IDX_LAST = cnt_width'(win_len - 1);

    state_t                        state;
    logic signed [input_width-1:0] x_prev;
    logic [cnt_width-1:0]          idx;

    logic signed [input_width:0]   diff;
    logic signed [input_width:0]   abs_diff;
    logic [cnt_width-1:0]          idx_nxt;

    // One extra bit of headroom: the difference of two input_width-bit
    // values always fits, and its magnitude never reaches the most negative
    // code, so the negation below is exact.
    assign diff     = {bus.din[input_width-1], bus.din} - {x_prev[input_width-1], x_prev};
    assign abs_diff = diff[input_width] ? -diff : diff;
    assign idx_nxt  = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= PRIME;
            x_prev        <= '0;
            idx           <= '0;
            bus.dout      <= '0;
            bus.dout_en   <= 1'b0;
            bus.win_first <= 1'b0;
            bus.win_last  <= 1'b0;
            bus.win_cnt   <= '0;
        end else if (bus.clr) begin
            // A sample arriving with clr is dropped, not used as the prime.
            state         <= PRIME;
            idx           <= '0;
            bus.dout      <= '0;
            bus.dout_en   <= 1'b0;
            bus.win_first <= 1'b0;
            bus.win_last  <= 1'b0;
            bus.win_cnt   <= '0;
        end else if (bus.din_valid) begin
            x_prev <= bus.din;
            case (state)
                PRIME: begin
                    state         <= RUN;
                    bus.dout_en   <= 1'b0;
                    bus.win_first <= 1'b0;
                    bus.win_last  <= 1'b0;
                end
                RUN: begin
                    // x_prev carries across window boundaries: no re-prime.
                    bus.dout      <= abs_diff;
                    bus.dout_en   <= 1'b1;
                    bus.win_first <= (idx == '0);
                    bus.win_last  <= (idx == IDX_LAST);
                    bus.win_cnt   <= idx;
                    idx           <= idx_nxt;
                end
                default: state <= PRIME;
            endcase
        end else begin
            // Idle: strobes drop, dout/win_cnt keep their last values.
            bus.dout_en   <= 1'b0;
            bus.win_first <= 1'b0;
            bus.win_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_linelen_frontend.sv
module tb_linelen_frontend;

    localparam int IW = 36;
    localparam int WL = 4;
    localparam int CW = 2;

    typedef struct {
        logic [IW:0]   dout;
        logic          first;
        logic          last;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q[$];
    int   n_checks;
    int   n_fails;
    int   n_pulses;

    linelen_frontend_if #(.input_width(IW), .cnt_width(CW)) bus ();

    linelen_frontend #(.input_width(IW), .win_len(WL), .cnt_width(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input longint d, input logic f, input logic l, input int c);
        exp_t e;
        logic [63:0] dv;
        dv      = d;
        e.dout  = dv[IW:0];
        e.first = f;
        e.last  = l;
        e.cnt   = CW'(c);
        q.push_back(e);
    endtask

    // Drive one cycle of stimulus, then at the following falling edge pop
    // and compare any produced difference against the scoreboard.
    task automatic step(input logic v, input longint d, input logic c);
        exp_t e;
        logic [63:0] dv;
        dv            = d;
        bus.din       = dv[IW-1:0];
        bus.din_valid = v;
        bus.clr       = c;
        @(posedge clk);
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.clr       = 1'b0;
        if (bus.dout_en === 1'b1) begin
            n_pulses++;
            n_checks++;
            if (q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_dout_en: got dout=%0d, required no output", bus.dout);
            end else begin
                e = q.pop_front();
                n_checks++;
                if (bus.dout !== e.dout) begin
                    n_fails++;
                    $display("FAIL dout: got %0d, required %0d", bus.dout, e.dout);
                end
                n_checks++;
                if (bus.win_first !== e.first) begin
                    n_fails++;
                    $display("FAIL win_first: got %b, required %b", bus.win_first, e.first);
                end
                n_checks++;
                if (bus.win_last !== e.last) begin
                    n_fails++;
                    $display("FAIL win_last: got %b, required %b", bus.win_last, e.last);
                end
                n_checks++;
                if (bus.win_cnt !== e.cnt) begin
                    n_fails++;
                    $display("FAIL win_cnt: got %0d, required %0d", bus.win_cnt, e.cnt);
                end
            end
        end else begin
            n_checks++;
            if (bus.dout_en !== 1'b0 || bus.win_first !== 1'b0 || bus.win_last !== 1'b0) begin
                n_fails++;
                $display("FAIL idle_strobes: got en/first/last=%b%b%b, required 000",
                         bus.dout_en, bus.win_first, bus.win_last);
            end
        end
    endtask

    task automatic drain(input string name);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        n_checks++;
        if (q.size() != 0) begin
            n_fails++;
            $display("FAIL %s_missing_outputs: got %0d pending, required 0", name, q.size());
        end
        q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.dout_en !== 1'b0 || bus.win_first !== 1'b0 || bus.win_last !== 1'b0 ||
            bus.dout !== '0 || bus.win_cnt !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got en=%b first=%b last=%b dout=%0d cnt=%0d, required all 0",
                     bus.dout_en, bus.win_first, bus.win_last, bus.dout, bus.win_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        #2;
        do_reset();
    endtask

    task automatic test_basic();
        step(1'b1, 10, 1'b0);
        push(3, 1'b1, 1'b0, 0);  step(1'b1, 13, 1'b0);
        push(6, 1'b0, 1'b0, 1);  step(1'b1, 7, 1'b0);
        push(0, 1'b0, 1'b0, 2);  step(1'b1, 7, 1'b0);
        push(12, 1'b0, 1'b1, 3); step(1'b1, -5, 1'b0);
        drain("basic");
    endtask

    task automatic test_extremes();
        longint mn, mx, full;
        mn   = -(64'sd1 <<< 35);
        mx   = (64'sd1 <<< 35) - 1;
        full = (64'sd1 <<< 36) - 1;
        do_reset();
        step(1'b1, mn, 1'b0);
        push(full, 1'b1, 1'b0, 0); step(1'b1, mx, 1'b0);
        push(full, 1'b0, 1'b0, 1); step(1'b1, mn, 1'b0);
        drain("extremes");
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b1, 0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            push(1, ((i - 1) % WL) == 0, ((i - 1) % WL) == WL - 1, (i - 1) % WL);
            step(1'b1, i, 1'b0);
        end
        drain("wrap");
    endtask

    task automatic test_gapped();
        longint smp[4];
        int     hold_cnt;
        smp[0] = 0; smp[1] = 5; smp[2] = 5; smp[3] = 20;
        do_reset();
        n_pulses = 0;
        hold_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) push(5, 1'b1, 1'b0, 0);
            if (i == 2) push(0, 1'b0, 1'b0, 1);
            if (i == 3) push(15, 1'b0, 1'b0, 2);
            step(1'b1, smp[i], 1'b0);
            if (i > 0) hold_cnt = i - 1;
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 0, 1'b0);
                n_checks++;
                if (bus.win_cnt !== CW'(hold_cnt)) begin
                    n_fails++;
                    $display("FAIL gap_win_cnt: got %0d, required %0d", bus.win_cnt, hold_cnt);
                end
            end
        end
        n_checks++;
        if (n_pulses != 3) begin
            n_fails++;
            $display("FAIL gapped_pulse_count: got %0d, required 3", n_pulses);
        end
        drain("gapped");
    endtask

    task automatic test_clr();
        do_reset();
        step(1'b1, 1, 1'b0);
        push(3, 1'b1, 1'b0, 0); step(1'b1, 4, 1'b0);
        push(6, 1'b0, 1'b0, 1); step(1'b1, 10, 1'b0);
        step(1'b1, 50, 1'b1);   // dropped with clr
        step(1'b1, 100, 1'b0);  // prime only
        push(3, 1'b1, 1'b0, 0); step(1'b1, 103, 1'b0);
        drain("clr");
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 0, 1'b0);
        push(7, 1'b1, 1'b0, 0); step(1'b1, 7, 1'b0);
        push(7, 1'b0, 1'b0, 1); step(1'b1, 14, 1'b0);
        n_checks++;
        if (bus.dout_en !== 1'b1) begin
            n_fails++;
            $display("FAIL pre_reset_en: got %b, required 1", bus.dout_en);
        end
        #1;
        do_reset();
        step(1'b1, 5, 1'b0);
        push(4, 1'b1, 1'b0, 0); step(1'b1, 9, 1'b0);
        drain("async_reset");
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        n_pulses      = 0;
        rst           = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.clr       = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_wrap();
        test_gapped();
        test_clr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/linelen_frontend.md
# linelen_frontend

Upstream feature stage for the line-length path: takes raw signed samples with a valid strobe, forms the absolute first difference |x[n] − x[n−1]|, and presents it to the accumulator (accu_unit) as a one-cycle `dout`/`dout_en` pair. It also frames the stream into fixed-length windows, flagging the first and last difference of each window so the downstream accumulator/threshold logic knows when a line-length sum is complete.

## Interface

- `input_width`, 36: width of signed input samples; `dout` is `input_width+1`, which matches accu_unit `input_width` = 37.
- `win_len`, 256: differences per window, ≥ 2.
- `cnt_width`, 8: width of `win_cnt`, equal to clog2(`win_len`).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  `input_width`  signed sample.
- `din_valid`  in  1  `din` is valid this cycle.
- `clr`  in  1  synchronous restart: discard the previous sample and the window position.
- `dout`  out  `input_width+1`  signed absolute difference, always ≥ 0.
- `dout_en`  out  1  `dout` valid; drives accu_unit `en`.
- `win_first`  out  1  qualifies `dout_en`: first difference of a window.
- `win_last`  out  1  qualifies `dout_en`: last difference of a window.
- `win_cnt`  out  `cnt_width`  index of the current `dout` within its window, 0..`win_len`−1.

## Operation

- State machine, 2 states:
  - PRIME: no previous sample is held. On `din_valid`: store `din` in `x_prev`, go to RUN, produce no output.
  - RUN: on `din_valid`: compute diff = `din` − `x_prev`, sign-extended to `input_width+1` bits. `dout` ← |diff|. Store `din` in `x_prev`. Assert `dout_en` for one cycle.
- Arithmetic:
  - The difference is computed in `input_width+1` bits, so it cannot overflow.
  - |diff| ≤ 2^`input_width` − 1, so it fits in `input_width+1` bits as a signed value.
  - Negation of the most-negative (`input_width+1`)-bit value cannot occur.
- Window counter `idx`:
  - Advances once per emitted difference.
  - Wraps from `win_len`−1 to 0.
  - `win_first` = (`idx` == 0). `win_last` = (`idx` == `win_len`−1).
  - `win_cnt` = `idx` for the emitted sample.
  - Windows are contiguous and non-overlapping. `x_prev` carries across window boundaries, so there is no re-prime between windows.
- `clr` (synchronous, highest priority after `rst`):
  - Forces PRIME, sets `idx` to 0, forces outputs low next cycle.
  - A `din_valid` in the same cycle as `clr` is discarded and is not used as the prime sample.
- `din_valid` low: state, `x_prev` and `idx` hold. `dout_en`, `win_first` and `win_last` deassert. `dout` and `win_cnt` hold their last values.
- There is no backpressure: every `din_valid` is consumed.

## Timing

- Reset values (asynchronous on `rst` high): state = PRIME, `x_prev` = 0, `idx` = 0, `dout` = 0, `dout_en` = 0, `win_first` = 0, `win_last` = 0, `win_cnt` = 0.
- Latency: a sample accepted on edge k produces its `dout`/`dout_en` after edge k, valid for the k+1 sample window. All outputs are registered.
- Throughput: one difference per cycle with `din_valid` held high continuously.
- After reset or `clr`, the first valid sample produces no output. Output starts with the second valid sample.
- Reset asserted mid-window: outputs clear immediately with no clock needed. After release, the block re-primes and the next window starts at `idx` 0.
- `win_first`, `win_last` and `win_cnt` are only meaningful while `dout_en` = 1.

## Test plan

Bench parameters: `input_width` = 36, `win_len` = 4.

1. Reset then stream 10, 13, 7, 7, −5 with `din_valid` continuous:
   - No output for 10.
   - `dout` = 3, 6, 0, 12 on consecutive cycles starting 1 cycle after 13 is accepted.
   - `win_first` on the 3, `win_last` on the 12, `win_cnt` = 0, 1, 2, 3.
2. Extremes: prime −2^35, then 2^35−1:
   - `dout` = 2^36−1, positive.
   - Then 2^35−1 followed by −2^35 gives the same value.
3. Window wrap: 9 consecutive samples of ramp 0, 1, …, 8:
   - 8 outputs of 1.
   - `win_last` on outputs 4 and 8, `win_first` on outputs 1 and 5.
   - Second window continues from `x_prev` = 4, with no re-prime.
4. Gapped valid: samples 0, 5, 5, 20 with 3 idle cycles between each:
   - `dout_en` pulses exactly 3 times, `dout` = 5, 0, 15.
   - Outputs low during gaps, `win_cnt` increments only on pulses.
5. `clr` mid-window, asserted together with a valid sample after 2 outputs:
   - That sample is dropped.
   - The next sample only primes, with no output.
   - The following output has `win_first` = 1, `win_cnt` = 0.
6. Asynchronous reset asserted between edges during streaming:
   - All outputs 0 before the next edge.
   - After release, the first valid sample produces no output.
